mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit that sits beside the combinational ALU in the MIPS execute stage.
- Accepts mult/multu/div/divu requests from the decode/control path through a start/busy/done handshake.
- Holds results in HI/LO for mfhi/mflo, and services mthi/mtlo writes.
- Returns its answer over many cycles, where the ALU answers in one.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; accepted only when busy=0
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu
- a  in  WIDTH  rs operand (dividend / multiplicand)
- b  in  WIDTH  rt operand (divisor / multiplier)
- hi_we  in  1  mthi write enable
- lo_we  in  1  mtlo write enable
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, and all internal registers 0. Reset mid-operation aborts the operation and produces no done.
- States:
  - IDLE: on start, go to CALC.
  - CALC: 32 iterations, then go to FIX.
  - FIX: go to IDLE.
- Edge E0 (start=1 in IDLE):
  - Latch op, |a|, |b| (absolute values for signed ops) and the result signs.
  - Counter cnt=0; busy=1 from E0.
- Edges E1..E32: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. At E32 go to FIX.
- Edge E33:
  - Apply sign correction.
  - Write hi/lo, done=1 for exactly one cycle, busy=0, return to IDLE.
  - Latency from start edge to done-visible: 33 edges.
- Multiply results: hi:lo = 64-bit product, two's complement for mult.
- Divide results: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- Divide by zero (b=0, div or divu): hi=a, lo=32'hFFFFFFFF. The operation still takes the full latency.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- start while busy=1 is ignored: no queueing, no error flag.
- hi_we/lo_we:
  - In IDLE, write wdata on the next edge.
  - While busy, ignored.
  - Simultaneous start and hi_we/lo_we in IDLE: the write takes effect at E0; the operation result overwrites it at E33.
- hi/lo are stable except at E0 (mt writes) and E33. Intermediate partial results live in separate registers.
- done never asserts on mthi/mtlo.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - mult/multu compute with a single-cycle signed/unsigned 64-bit product.
  - FIX is entered directly at E1; result written and done pulsed at E2; busy high for 2 cycles.
  - Divide is unchanged.
- Undefined: all ops use the 33-edge iterative path. Bench latency checks must key off the macro.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state encoding (S_IDLE, S_CALC, S_FIX);
  - constants ITER_LAST=WIDTH-1 and DIV0_LO=all-ones.
- One natural sub-module: mdu_step. It is a combinational single-iteration datapath (shift-add / shift-subtract, selected by a mode bit) that mdu_iter registers each CALC cycle.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 33 edges after start; busy high exactly 33 cycles.
- mult a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. divu a=100 b=7 -> lo=14, hi=2.
- div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=0x1234 b=0 -> hi=0x1234, lo=0xFFFFFFFF, normal latency.
- start mult 6*7, re-pulse start with divu at cycle 5, and assert hi_we wdata=0xDEAD at cycle 8 -> both ignored; hi=0, lo=42; single done pulse.
- Start divu 100/7, drop rst_n at cycle 10 -> busy=0, hi=lo=0 immediately, no done afterwards. After release, mtlo 0xABCD in IDLE gives lo=0xABCD next cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the iterative multiply/divide unit.
//   - op encodings carried on the request bus
//   - FSM state encodings (legacy-compatible localparam constants)
//   - default datapath width, last iteration index, divide-by-zero LO value
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_FIX  = 2'b10;

  localparam int ITER_LAST = MDU_WIDTH - 1;
  localparam logic [MDU_WIDTH-1:0] DIV0_LO = {MDU_WIDTH{1'b1}};

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response bundle between the decode/control path and
// the multiply/divide unit.
//   master (control path): drives start, op, a, b, hi_we, lo_we, wdata
//   slave  (mdu_iter)     : drives busy, done, hi, lo
interface mdu_iter_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   i_div  - 0: shift-add multiply step, 1: restoring shift-subtract step
//   i_p    - working register {upper, lower}
//            multiply: {partial product, remaining multiplier bits}
//            divide  : {partial remainder, dividend/quotient bits}
//   i_opnd - multiplicand (multiply) or divisor (divide), magnitude only
//   o_p    - working register after this iteration
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_p
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Single iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
  always_comb begin
    w_sum   = {1'b0, i_p[2*WIDTH-1:WIDTH]} +
              (i_p[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
    w_shift = i_p[2*WIDTH-1:WIDTH-1];
    w_ge    = (w_shift >= {1'b0, i_opnd});
    // Remainder stays below the divisor, so the true difference fits in WIDTH bits
    w_diff  = w_shift[WIDTH-1:0] - i_opnd;
    if (i_div) begin
      if (w_ge) begin
        o_p = {w_diff, i_p[WIDTH-2:0], 1'b1};
      end else begin
        o_p = {w_shift[WIDTH-1:0], i_p[WIDTH-2:0], 1'b0};
      end
    end else begin
      o_p = {w_sum, i_p[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MIPS multiply/divide unit with HI/LO registers.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mdu_iter_if.slave: start/op/a/b request, hi_we/lo_we/wdata
//           mthi/mtlo writes, busy/done status, hi/lo results
// Operation: magnitudes are processed unsigned for WIDTH iterations in
// S_CALC, signs are applied in S_FIX, which writes HI/LO and pulses done.
// Build option: MDU_FAST_MULT_EN makes mult/multu finish in one S_CALC cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  mdu_iter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_div),
    .i_p    (r_p),
    .i_opnd (r_opnd),
    .o_p    (w_p_next)
  );

  // Decode the incoming request and take operand magnitudes for signed ops
  always_comb begin
    w_is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    w_a_neg  = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.a[WIDTH-1];
    w_b_neg  = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) && bus.b[WIDTH-1];
    w_abs_a  = w_a_neg ? -bus.a : bus.a;
    w_abs_b  = w_b_neg ? -bus.b : bus.b;
  end

  // Sign correction of the finished magnitude result; remainder follows the dividend
  always_comb begin
    w_prod = r_neg_q ? -r_p : r_p;
    w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
    if (r_div) begin
      w_hi_fix = w_rem;
      w_lo_fix = r_div0 ? {WIDTH{1'b1}} : w_quo;
    end else begin
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_lo_fix = w_prod[WIDTH-1:0];
    end
  end

  // Control FSM, iteration datapath and HI/LO architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_p     <= {(2*WIDTH){1'b0}};
      r_opnd  <= {WIDTH{1'b0}};
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (bus.start) begin
            // Divide iterates on the dividend, multiply on the multiplier
            r_p     <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_opnd  <= w_is_div ? w_abs_b : w_abs_a;
            r_div   <= w_is_div;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= w_is_div && (bus.b == {WIDTH{1'b0}});
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
`ifdef MDU_FAST_MULT_EN
          if (!r_div) begin
            r_p     <= {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_p[WIDTH-1:0]};
            r_state <= S_FIX;
          end else begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + CNT_W'(1'b1);
            if (r_cnt == CNT_LAST) r_state <= S_FIX;
          end
`else
          r_p   <= w_p_next;
          r_cnt <= r_cnt + CNT_W'(1'b1);
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
`endif
        end
        S_FIX: begin
          r_hi    <= w_hi_fix;
          r_lo    <= w_lo_fix;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter.
// Latency expectations follow MDU_FAST_MULT_EN when it is defined.
module tb_mdu_iter;
  import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int PULSE_C = 1;
  localparam int WE_C    = 1;
`else
  localparam int PULSE_C = 5;
  localparam int WE_C    = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mdu_iter_if #(.WIDTH(32)) bus ();

  mdu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency and busy width, check result and done width
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    int busy_cnt;
    int lat_exp;
    lat_exp = 33;
`ifdef MDU_FAST_MULT_EN
    if (op == OP_MULT || op == OP_MULTU) lat_exp = 2;
`endif
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    check_eq($sformatf("%s_done", tag), 64'(bus.done), 64'd1);
    check_eq($sformatf("%s_lat", tag), 64'(lat), 64'(lat_exp));
    check_eq($sformatf("%s_busy_cycles", tag), 64'(busy_cnt), 64'(lat_exp));
    check_eq($sformatf("%s_busy_low", tag), 64'(bus.busy), 64'd0);
    check_eq($sformatf("%s_hi", tag), 64'(bus.hi), 64'(ehi));
    check_eq($sformatf("%s_lo", tag), 64'(bus.lo), 64'(elo));
    tick();
    check_eq($sformatf("%s_done_pulse", tag), 64'(bus.done), 64'd0);
  endtask

  initial begin
    int dcount;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'h0;
    #12;
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi", 64'(bus.hi), 64'd0);
    check_eq("rst_lo", 64'(bus.lo), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF);

    // mult 6*7 with a stray start and an mthi while busy
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 60; c++) begin
      bus.start = (c == PULSE_C);
      bus.op    = OP_DIVU;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.hi_we = (c == WE_C);
      bus.wdata = 32'hDEAD;
      tick();
      if (bus.done) dcount++;
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check_eq("ign_done_count", 64'(dcount), 64'd1);
    check_eq("ign_hi", 64'(bus.hi), 64'd0);
    check_eq("ign_lo", 64'(bus.lo), 64'd42);
    check_eq("ign_busy", 64'(bus.busy), 64'd0);

    // Reset in the middle of a divide
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check_eq("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_rst_hi", 64'(bus.hi), 64'd0);
    check_eq("mid_rst_lo", 64'(bus.lo), 64'd0);
    check_eq("mid_rst_done", 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.done) dcount++;
    end
    check_eq("mid_rst_no_done", 64'(dcount), 64'd0);
    check_eq("mid_rst_idle_busy", 64'(bus.busy), 64'd0);

    // mtlo in IDLE
    bus.lo_we = 1'b1;
    bus.wdata = 32'hABCD;
    tick();
    bus.lo_we = 1'b0;
    check_eq("mtlo_lo", 64'(bus.lo), 64'h0000ABCD);
    check_eq("mtlo_hi", 64'(bus.hi), 64'd0);
    check_eq("mtlo_no_done", 64'(bus.done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
